// File: rtl/uart_pkg.sv
// Shared definitions for the UART channel blocks and their upload arbiters.
package uart_pkg;

    localparam int CH_IDX_W    = 5;
    localparam int AXIS_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_rr_select.sv
// Combinational round-robin picker: first set request bit strictly after ptr,
// wrapping, returned as a one-hot grant plus its index.
module uart_rr_select
    import uart_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]     req,
    input  logic [CH_IDX_W-1:0] ptr,
    output logic [N_CH-1:0]     gnt,
    output logic [CH_IDX_W-1:0] gidx,
    output logic                any
);

    always_comb begin
        int c;
        gnt  = '0;
        gidx = '0;
        any  = 1'b0;
        c    = 0;
        // ptr itself is searched last, so the channel just served has lowest priority.
        for (int off = 1; off <= N_CH; off++) begin
            c = (int'(ptr) + off) % N_CH;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                gidx   = CH_IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/uart_upload_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream upload port among
// N_CH UART channels, with source tagging in tid and an inactivity timeout.
module uart_upload_arbiter
    import uart_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CH-1:0]             ch_enable,
    input  logic [N_CH-1:0]             pkt_valid,
    input  logic [N_CH-1:0]             skip_arb,
    input  logic [N_CH*AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]             s_axis_tvalid,
    output logic [N_CH-1:0]             s_axis_tready,
    input  logic [N_CH-1:0]             s_axis_tlast,
    input  logic [N_CH*CH_IDX_W-1:0]    s_axis_tdest,
    output logic [AXIS_DATA_W-1:0]      m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [CH_IDX_W-1:0]         m_axis_tid,
    output logic [CH_IDX_W-1:0]         m_axis_tdest,
    output logic [N_CH-1:0]             grant,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        timeout_err,
    input  logic                        err_clr
);

    // A timeout of zero means "never release a stalled grant".
    localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [N_CH-1:0]     grant_q, grant_d;
    logic [CH_IDX_W-1:0] gidx_q, gidx_d;
    logic [CH_IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pkt_done_q, pkt_done_d;
    logic                timeout_err_q, timeout_err_d;

    logic [N_CH-1:0]     eligible;
    logic [N_CH-1:0]     sel_gnt;
    logic [CH_IDX_W-1:0] sel_idx;
    logic                sel_any;

    logic                   g_tvalid;
    logic                   g_tlast;
    logic [AXIS_DATA_W-1:0] g_tdata;
    logic [CH_IDX_W-1:0]    g_tdest;
    logic                   hs;
    logic                   err_set;

    assign eligible = pkt_valid & ~skip_arb & ch_enable;

    uart_rr_select #(
        .N_CH (N_CH)
    ) u_rr_select (
        .req  (eligible),
        .ptr  (ptr_q),
        .gnt  (sel_gnt),
        .gidx (sel_idx),
        .any  (sel_any)
    );

    // Pass-through mux of the granted channel; no buffering on the data path.
    always_comb begin
        g_tvalid = 1'b0;
        g_tlast  = 1'b0;
        g_tdata  = '0;
        g_tdest  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gidx_q == CH_IDX_W'(i)) begin
                g_tvalid = s_axis_tvalid[i];
                g_tlast  = s_axis_tlast[i];
                g_tdata  = s_axis_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
                g_tdest  = s_axis_tdest[i*CH_IDX_W +: CH_IDX_W];
            end
        end
    end

    assign busy          = (state_q == XFER);
    assign m_axis_tvalid = busy & g_tvalid;
    assign m_axis_tdata  = g_tdata;
    assign m_axis_tlast  = g_tlast;
    assign m_axis_tdest  = g_tdest;
    assign m_axis_tid    = gidx_q;
    assign s_axis_tready = (busy && m_axis_tready) ? grant_q : '0;
    assign grant         = grant_q;
    assign pkt_done      = pkt_done_q;
    assign timeout_err   = timeout_err_q;

    assign hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        pkt_done_d = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_any) begin
                    state_d = XFER;
                    grant_d = sel_gnt;
                    gidx_d  = sel_idx;
                end
            end
            XFER: begin
                if (hs && m_axis_tlast) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    ptr_d      = gidx_q;
                    cnt_d      = '0;
                    pkt_done_d = 1'b1;
                end else if (hs) begin
                    cnt_d = '0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    // Forced release: the partial packet stays unterminated downstream.
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    cnt_d   = '0;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (err_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= CH_IDX_W'(N_CH - 1);
            cnt_q         <= '0;
            pkt_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            pkt_done_q    <= pkt_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_upload_arbiter.sv
// Bench for uart_upload_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a behavioural owner/round-robin model.
module tb_uart_upload_arbiter;

    localparam int NC = 4;
    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic [3:0]  ch_enable, pkt_valid, skip_arb;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tready, s_tlast;
    logic [19:0] s_tdest;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [4:0]  m_tid, m_tdest;
    logic [3:0]  grant;
    logic        busy, pkt_done, timeout_err, err_clr;

    uart_upload_arbiter #(.N_CH(NC), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ch_enable(ch_enable), .pkt_valid(pkt_valid),
        .skip_arb(skip_arb), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
        .grant(grant), .busy(busy), .pkt_done(pkt_done), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which channel owns the port (-1 = none), who was served last,
    // how many consecutive cycles the owner went without a transfer.
    int m_owner, m_last, m_run;
    bit m_err, m_done;

    // Packet sources: packets pending, packet length, current beat, tvalid hold-off.
    bit src_mode;
    int src_pkts[NC];
    int plen[NC];
    int bc[NC];
    bit src_hold[NC];

    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];
    int n_hs, n_done, n_busy, n_other_rdy;
    bit prev_stall;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NC; i++) begin
            pkt_valid[i]       = (src_pkts[i] > 0);
            s_tvalid[i]        = (src_pkts[i] > 0) && !src_hold[i];
            s_tdata[i*8 +: 8]  = 8'hA1 + 8'(bc[i]) + 8'(i * 16);
            s_tlast[i]         = (bc[i] == plen[i] - 1);
            s_tdest[i*5 +: 5]  = 5'(i + 8);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        n_hs = 0; n_done = 0; n_busy = 0; n_other_rdy = 0;
    endtask

    // One cycle: check outputs against the model, cross the edge, advance model and sources.
    task automatic step();
        int o, c;
        logic exp_v;
        logic [3:0] exp_rdy, elig;
        bit hs, hs_last, set_err, found;
        #1;
        o = m_owner;
        check("busy", busy, (o >= 0));
        check("grant", grant, (o >= 0) ? (32'd1 << o) : 32'd0);
        exp_v = (o >= 0) ? s_tvalid[o] : 1'b0;
        check("m_tvalid", m_tvalid, exp_v);
        exp_rdy = (o >= 0 && m_tready) ? 4'(1 << o) : 4'd0;
        check("s_tready", s_tready, exp_rdy);
        check("pkt_done", pkt_done, m_done);
        check("timeout_err", timeout_err, m_err);
        if (exp_v) begin
            check("m_tdata", m_tdata, s_tdata[o*8 +: 8]);
            check("m_tlast", m_tlast, s_tlast[o]);
            check("m_tid", m_tid, o);
            check("m_tdest", m_tdest, s_tdest[o*5 +: 5]);
        end
        if (src_mode && prev_stall && m_tvalid) check("stall_hold", m_tdata, prev_data);
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        hs      = exp_v && m_tready;
        hs_last = hs && s_tlast[o];
        if (m_tvalid && m_tready) begin
            n_hs++;
            if (m_tlast) got_q.push_back(m_tid);
        end
        if (pkt_done) n_done++;
        if (busy) n_busy++;
        if ((s_tready & 4'b1101) != 4'b0) n_other_rdy++;
        elig = pkt_valid & ~skip_arb & ch_enable;
        @(posedge clk);
        set_err = 1'b0;
        if (reset) begin
            m_owner = -1; m_last = NC - 1; m_run = 0; m_err = 1'b0; m_done = 1'b0;
            prev_stall = 1'b0;
        end else begin
            m_done = 1'b0;
            if (o < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NC; k++) begin
                    c = (m_last + k) % NC;
                    if (!found && elig[c]) begin
                        found = 1'b1; m_owner = c; m_run = 0;
                    end
                end
            end else if (hs_last) begin
                m_last = o; m_owner = -1; m_done = 1'b1;
            end else if (hs) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == TO) begin
                    m_last = o; m_owner = -1; set_err = 1'b1;
                end
            end
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        if (src_mode && hs) begin
            if (s_tlast[o]) begin
                bc[o] = 0;
                src_pkts[o]--;
            end else begin
                bc[o]++;
            end
        end
        @(negedge clk);
        if (src_mode) drive_src();
    endtask

    task automatic src_idle();
        for (int i = 0; i < NC; i++) begin
            src_pkts[i] = 0; plen[i] = 2; bc[i] = 0; src_hold[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        src_idle();
        if (src_mode) drive_src();
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NC; i++) if (src_pkts[i] > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_drained(input string tag, input int budget);
        int t;
        t = 0;
        while ((!src_empty() || busy) && t < budget) begin
            step();
            t++;
        end
        check({tag, "_drained"}, (t < budget), 1);
        repeat (2) step();
    endtask

    int cnt;
    logic [3:0] rpat;

    initial begin
        reset = 1'b1; err_clr = 1'b0; m_tready = 1'b1;
        ch_enable = 4'hF; skip_arb = 4'h0;
        src_mode = 1'b1; src_idle(); drive_src();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_owner = -1; m_last = NC - 1; m_run = 0; m_err = 1'b0; m_done = 1'b0;
        clear_logs();
        do_reset();

        // 1: single 3-beat packet from channel 0
        clear_logs();
        plen[0] = 3; src_pkts[0] = 1; drive_src();
        step();
        check("t1_grant_next", grant, 4'b0001);
        run_until_drained("t1", 50);
        check("t1_beats", n_hs, 3);
        check("t1_done", n_done, 1);
        check("t1_npkt", got_q.size(), 1);
        if (got_q.size() > 0) check("t1_tid", got_q[0], 0);

        // 2: all four channels, two 2-beat packets each
        do_reset(); clear_logs();
        for (int i = 0; i < NC; i++) src_pkts[i] = 2;
        drive_src();
        exp_q = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3};
        run_until_drained("t2", 200);
        check("t2_npkt", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) check("t2_order", got_q[k], exp_q[k]);
        check("t2_busy_cycles", n_busy, 16);
        check("t2_done", n_done, 8);

        // 3: eligibility masking
        do_reset(); clear_logs();
        src_pkts[1] = 1; src_pkts[2] = 1; skip_arb = 4'b0010; ch_enable = 4'b1011; drive_src();
        repeat (6) step();
        check("t3_no_grant", n_busy, 0);
        ch_enable = 4'b1111;
        cnt = 0;
        while ((src_pkts[2] > 0 || busy) && cnt < 50) begin step(); cnt++; end
        repeat (3) step();
        check("t3_npkt", got_q.size(), 1);
        if (got_q.size() > 0) check("t3_tid", got_q[0], 2);
        skip_arb = 4'b0000; src_pkts[1] = 0; drive_src();

        // 4: back-pressure on a 4-beat packet from channel 1
        do_reset(); clear_logs();
        rpat = 4'b1001;
        plen[1] = 4; src_pkts[1] = 1; drive_src();
        cnt = 0;
        while ((!src_empty() || busy) && cnt < 60) begin
            m_tready = rpat[cnt % 4];
            step();
            cnt++;
        end
        m_tready = 1'b1;
        check("t4_drained", (cnt < 60), 1);
        check("t4_beats", n_hs, 4);
        check("t4_other_rdy", n_other_rdy, 0);
        check("t4_npkt", got_q.size(), 1);

        // 5: timeout after one beat from channel 3
        do_reset(); clear_logs();
        plen[3] = 4; src_pkts[3] = 1; drive_src();
        cnt = 0;
        while (bc[3] == 0 && cnt < 20) begin step(); cnt++; end
        check("t5_first_beat", bc[3], 1);
        src_hold[3] = 1'b1; plen[0] = 2; src_pkts[0] = 1; drive_src();
        cnt = 0;
        while (busy && cnt < 40) begin step(); cnt++; end
        check("t5_release_cycles", cnt, TO);
        check("t5_err_set", timeout_err, 1);
        check("t5_no_done", n_done, 0);
        src_pkts[3] = 0; src_hold[3] = 1'b0; bc[3] = 0; drive_src();
        step();
        check("t5_next_grant", grant, 4'b0001);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t5_err_clr", timeout_err, 0);
        run_until_drained("t5", 50);

        // 6: reset during the second beat of a 5-beat packet
        do_reset(); clear_logs();
        plen[0] = 5; src_pkts[0] = 1; drive_src();
        cnt = 0;
        while (!(busy && bc[0] == 1) && cnt < 20) begin step(); cnt++; end
        check("t6_mid_packet", bc[0], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_grant", grant, 0);
        check("t6_busy", busy, 0);
        check("t6_tready", s_tready, 0);
        src_idle(); clear_logs();
        for (int i = 0; i < NC; i++) src_pkts[i] = 1;
        drive_src();
        run_until_drained("t6", 100);
        check("t6_npkt", got_q.size(), 4);
        if (got_q.size() > 0) check("t6_first", got_q[0], 0);

        // 7: unconstrained random traffic against the model
        src_mode = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            pkt_valid = 4'($urandom_range(0, 15));
            skip_arb  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            ch_enable = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            s_tvalid  = 4'($urandom_range(0, 15));
            for (int i = 0; i < NC; i++) s_tlast[i] = ($urandom_range(0, 3) == 0);
            s_tdata   = $urandom;
            s_tdest   = 20'($urandom);
            m_tready  = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_upload_arbiter.md
Name: uart_upload_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one AXI-Stream upload port among N_CH UART channel blocks.
- Each channel block presents its rx stream (m_axis_*), its pkt_valid and its skip_arb.
- Sits between the per-channel UART wrappers and the single host upload path (DMA/packetiser).
- Tags each forwarded packet with its source channel in tid, and releases a stalled grant via an inactivity timeout.

Parameters:
- N_CH, 4, number of channels; range 2..16.
- TIMEOUT_CYC, 65535, cycles without a handshake while granted before the grant is forcibly released; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; TIMEOUT_CYC must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ch_enable  in  N_CH  per-channel arbitration enable (config register)
- pkt_valid  in  N_CH  channel i has at least one complete packet queued
- skip_arb  in  N_CH  channel i is being drained by software; exclude it from arbitration
- s_axis_tdata  in  N_CH*8  channel data; channel i occupies bits [8i+7:8i]
- s_axis_tvalid  in  N_CH  per-channel valid
- s_axis_tready  out  N_CH  per-channel ready
- s_axis_tlast  in  N_CH  per-channel last
- s_axis_tdest  in  N_CH*5  per-channel dest
- m_axis_tdata  out  8  shared output data
- m_axis_tvalid  out  1  shared output valid
- m_axis_tready  in  1  shared output ready
- m_axis_tlast  out  1  shared output last
- m_axis_tid  out  5  index of the granted channel
- m_axis_tdest  out  5  tdest of the granted channel
- grant  out  N_CH  one-hot current grant, registered
- busy  out  1  high while in XFER
- pkt_done  out  1  one-cycle pulse on the final beat handshake of a packet
- timeout_err  out  1  sticky; set on a forced release
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset values:
  - grant=0, busy=0, pkt_done=0, timeout_err=0, all s_axis_tready=0, m_axis_tvalid=0.
  - Round-robin pointer = N_CH-1, so channel 0 has first priority.
  - Timeout counter = 0. FSM = IDLE.
- Eligibility: eligible = pkt_valid & ~skip_arb & ch_enable.
- FSM IDLE:
  - If eligible≠0, choose the first set bit searching from ptr+1 upward, with wrap.
  - At the clock edge, register grant (one-hot) and gidx, then go to XFER.
  - All s_axis_tready=0 and m_axis_tvalid=0 while in IDLE.
- FSM XFER:
  - Combinational mux of the granted channel: m_axis_tvalid = s_axis_tvalid[gidx], s_axis_tready[gidx] = m_axis_tready, all other treadies 0.
  - m_axis_tdata, tlast and tdest come from gidx; m_axis_tid = gidx zero-extended to 5 bits.
  - On handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast): set pkt_done=1 in the next cycle, ptr←gidx, grant←0, go to IDLE.
- Latency:
  - eligible seen in cycle n → grant valid in cycle n+1 → first beat may transfer in cycle n+1.
  - One mandatory IDLE bubble between packets.
  - Zero added latency per beat (combinational pass-through); no buffering.
- Grant lock:
  - Changes to pkt_valid, skip_arb or ch_enable on the granted channel during XFER have no effect; the grant holds until tlast or timeout.
- Timeout:
  - In XFER the counter increments each cycle without a handshake and clears on any handshake.
  - When counter == TIMEOUT_CYC-1 and no handshake occurs that cycle: release the grant (go to IDLE, ptr←gidx), set timeout_err, no pkt_done.
  - No tlast is inserted; downstream framing is the software's concern.
- timeout_err:
  - Set has priority over a simultaneous err_clr.
  - Cleared only by err_clr or reset.
- Back-pressure: m_axis_tready low holds all outputs stable (AXIS rule); the timeout counter keeps running.
- Single eligible channel: re-granted after the bubble; pointer fairness is irrelevant in that case.
- Reset mid-packet: the grant is dropped immediately at the reset edge and all treadies go low; the partial packet is left in the channel FIFO.

Decomposition:
- Shared package uart_pkg holds:
  - CH_IDX_W=5 and AXIS_DATA_W=8.
  - The state enum {IDLE, XFER}.
- One sub-module, uart_rr_select (combinational): takes req[N_CH] and ptr, and returns a one-hot grant and its index. It is reused by other arbiters in the codebase.

Test Plan:
1. Reset, then pkt_valid=4'b0001 with channel 0 sending a 3-beat packet 0xA1,0xA2,0xA3 (tlast on the third), m_axis_tready=1 → grant=0001 one cycle after the request; 3 beats out with tid=0; pkt_done pulses once; busy falls.
2. pkt_valid=4'b1111, each channel sending a 2-beat packet, repeated twice → grant order 0,1,2,3,0,1,2,3; one IDLE cycle between packets; tid matches the source channel each time.
3. pkt_valid=4'b0110 with skip_arb=4'b0010 and ch_enable=4'b1011 → no grant issued; set ch_enable=4'b1111 → channel 2 granted only.
4. Channel 1 granted, then m_axis_tready toggled 1,0,0,1 each beat of a 4-beat packet → m_axis_tdata and tvalid stable during stalls; exactly 4 handshakes; s_axis_tready[0,2,3] stay 0 throughout.
5. TIMEOUT_CYC=16; channel 3 granted, sends one beat, then drops tvalid → grant released exactly 16 cycles after the last handshake; timeout_err=1; next eligible channel granted; err_clr pulse → timeout_err=0.
6. Assert reset in the middle of the second beat of a 5-beat packet → the cycle after the reset edge shows grant=0, busy=0, all treadies 0; after reset the first grant goes to channel 0 when all channels request.
